view_param_controller: RTL

// Per-frame view-parameter engine for the fractal renderer: turns button inputs into centre/zoom/iteration settings.

---
 rtl/view_param_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/view_param_controller.sv
// view_param_controller: per-frame view-parameter engine between the pad inputs and the iteration core.
// Ports: clk, rst (sync, active-high), v_begin frame strobe, ui_in/uio_in buttons (sticky-captured);
//        centre_x/centre_y, zoom_level, max_iter_limit registered params, params_changed pulse.
// Latency: inputs sampled on the v_begin cycle N appear at N+1. There is no backpressure; every frame start is accepted.
module view_param_controller #(
  parameter int COORD_WIDTH   = 16,
  parameter int FRAC_BITS     = 12,
  parameter int ZOOM_WIDTH    = 5,
  parameter int ZOOM_MAX      = 20,
  parameter int ITER_WIDTH    = 8,
  parameter int ITER_MIN      = 15,
  parameter int ITER_MAX      = 255,
  parameter int ITER_STEP     = 16,
  parameter int ITER_DEFAULT  = 63,
  parameter int DEFAULT_CX    = -(1 << (FRAC_BITS - 1)),
  parameter int DEFAULT_CY    = 0,
  parameter int BASE_PAN_STEP = 512,
  parameter int HOLD_FRAMES   = 8,
  parameter int ACCEL_MAX     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          v_begin,
  input  logic [7:0]                    ui_in,
  input  logic [7:0]                    uio_in,
  output logic signed [COORD_WIDTH-1:0] centre_x,
  output logic signed [COORD_WIDTH-1:0] centre_y,
  output logic [ZOOM_WIDTH-1:0]         zoom_level,
  output logic [ITER_WIDTH-1:0]         max_iter_limit,
  output logic                          params_changed
);
  localparam int SW      = COORD_WIDTH + ACCEL_MAX;
  localparam int CW      = COORD_WIDTH + 1;
  localparam int IW      = ITER_WIDTH + 1;
  localparam int CNT_MAX = HOLD_FRAMES * ACCEL_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_NEG = 2'd1, DIR_POS = 2'd2} dir_t;

  typedef struct packed {
    logic signed [COORD_WIDTH-1:0] coord;
    logic [CNT_W-1:0]              cnt;
    dir_t                          dir;
  } axis_t;

  // Command bits: [0]zoom_in [1]zoom_out [2]left [3]right [4]up [5]down [6]reset_view [7]iter_up [8]iter_down
  logic [8:0]            pending;
  logic [8:0]            cur;
  logic [8:0]            eff;
  logic [CNT_W-1:0]      cnt_x, cnt_y;
  dir_t                  dir_x, dir_y;
  axis_t                 ax, ay;
  logic [ZOOM_WIDTH-1:0] zoom_n;
  logic [ITER_WIDTH-1:0] iter_n;
  logic [IW-1:0]         iter_up;
  logic                  changed;
  logic                  unused_bits;

  assign cur         = {uio_in[1:0], ui_in[6:0]};
  assign eff         = pending | cur;
  assign unused_bits = ^{ui_in[7], uio_in[7:2]};

  // One axis of panning: direction tracking, hold acceleration, step and saturating move.
  function automatic axis_t pan_axis(input logic neg, input logic pos, input dir_t prev,
                                     input logic [CNT_W-1:0] cnt,
                                     input logic signed [COORD_WIDTH-1:0] c,
                                     input logic [ZOOM_WIDTH-1:0] z);
    axis_t                 r;
    logic [CNT_W-1:0]      used;
    int                    accel;
    logic [SW-1:0]         step;
    logic signed [CW-1:0]  sum;
    r.coord = c;
    r.cnt   = '0;
    r.dir   = DIR_NONE;
    used    = '0;
    accel   = 0;
    step    = '0;
    sum     = '0;
    if (neg ^ pos) begin
      r.dir = neg ? DIR_NEG : DIR_POS;
      // A new direction restarts acceleration from zero for this frame's step.
      used  = (r.dir == prev) ? cnt : '0;
      accel = int'(used) / HOLD_FRAMES;
      if (accel > ACCEL_MAX) accel = ACCEL_MAX;
      step = (SW'(BASE_PAN_STEP) << accel) >> z;
      // Deep zoom shifts the step to zero; keep at least one LSB of movement.
      if (step == '0) step = SW'(1);
      if (neg) sum = {c[COORD_WIDTH-1], c} - CW'(step);
      else     sum = {c[COORD_WIDTH-1], c} + CW'(step);
      // Sign and extra bit disagree only on overflow: saturate instead of wrapping.
      if (sum[CW-1] != sum[CW-2])
        r.coord = sum[CW-1] ? {1'b1, {(COORD_WIDTH-1){1'b0}}} : {1'b0, {(COORD_WIDTH-1){1'b1}}};
      else
        r.coord = sum[COORD_WIDTH-1:0];
      r.cnt = (used < CNT_W'(CNT_MAX)) ? used + CNT_W'(1) : CNT_W'(CNT_MAX);
    end
    return r;
  endfunction

  always_comb begin
    ax = pan_axis(eff[2], eff[3], dir_x, cnt_x, centre_x, zoom_level);
    ay = pan_axis(eff[4], eff[5], dir_y, cnt_y, centre_y, zoom_level);

    zoom_n = zoom_level;
    if (eff[0] && !eff[1] && zoom_level < ZOOM_WIDTH'(ZOOM_MAX))
      zoom_n = zoom_level + ZOOM_WIDTH'(1);
    else if (eff[1] && !eff[0] && zoom_level != '0)
      zoom_n = zoom_level - ZOOM_WIDTH'(1);

    iter_n  = max_iter_limit;
    iter_up = {1'b0, max_iter_limit} + IW'(ITER_STEP);
    if (eff[7] && !eff[8])
      iter_n = (iter_up > IW'(ITER_MAX)) ? ITER_WIDTH'(ITER_MAX) : iter_up[ITER_WIDTH-1:0];
    else if (eff[8] && !eff[7])
      iter_n = ({1'b0, max_iter_limit} < IW'(ITER_MIN + ITER_STEP)) ? ITER_WIDTH'(ITER_MIN)
                                                                    : max_iter_limit - ITER_WIDTH'(ITER_STEP);

    // Recentre wins over every other command that frame; the iteration limit is kept.
    // The frame counts as "no direction" so the next press starts a fresh hold.
    if (eff[6]) begin
      ax.coord = COORD_WIDTH'(DEFAULT_CX);
      ax.cnt   = '0;
      ax.dir   = DIR_NONE;
      ay.coord = COORD_WIDTH'(DEFAULT_CY);
      ay.cnt   = '0;
      ay.dir   = DIR_NONE;
      zoom_n   = '0;
      iter_n   = max_iter_limit;
    end

    changed = (ax.coord != centre_x) || (ay.coord != centre_y) ||
              (zoom_n != zoom_level) || (iter_n != max_iter_limit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      centre_x       <= COORD_WIDTH'(DEFAULT_CX);
      centre_y       <= COORD_WIDTH'(DEFAULT_CY);
      zoom_level     <= '0;
      max_iter_limit <= ITER_WIDTH'(ITER_DEFAULT);
      params_changed <= 1'b0;
      cnt_x          <= '0;
      cnt_y          <= '0;
      dir_x          <= DIR_NONE;
      dir_y          <= DIR_NONE;
    end else if (v_begin) begin
      pending        <= '0;
      centre_x       <= ax.coord;
      centre_y       <= ay.coord;
      zoom_level     <= zoom_n;
      max_iter_limit <= iter_n;
      params_changed <= changed;
      cnt_x          <= ax.cnt;
      cnt_y          <= ay.cnt;
      dir_x          <= ax.dir;
      dir_y          <= ay.dir;
    end else begin
      pending        <= eff;
      params_changed <= 1'b0;
    end
  end
endmodule
